// File: rtl/roi_harness_pkg.sv
// Shared definitions for the ROI harness sequencer and the benches that drive it.
package roi_harness_pkg;

  // Sequencer states, in the order a transaction walks through them.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT1,
    ST_STB1,
    ST_SHIFT2,
    ST_STB2,
    ST_READ,
    ST_DONE
  } state_t;

  // Counter width: enough bits to count 0..max(din_n,dout_n)-1.
  function automatic int cnt_w(input int din_n, input int dout_n);
    int m;
    m = (din_n > dout_n) ? din_n : dout_n;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // Cycles from the accept edge to the DONE cycle.
  function automatic int txn_len(input int din_n, input int dout_n);
    return 2 * din_n + dout_n + 3;
  endfunction

  localparam int DIN_N_DEF  = 256;
  localparam int DOUT_N_DEF = 256;
  localparam int TXN_LEN    = 2 * DIN_N_DEF + DOUT_N_DEF + 3;

endpackage

// File: rtl/roi_harness_seq_if.sv
// Host request/readback signals plus the serial pins to the harness.
interface roi_harness_seq_if #(
  parameter int DIN_N  = 256,
  parameter int DOUT_N = 256
);
  logic              start;
  logic [DIN_N-1:0]  wdata;
  logic              busy;
  logic              done;
  logic [DOUT_N-1:0] rdata;
  logic              sdi;
  logic              stb;
  logic              sdo;

  // Driver side: the host issuing requests and the harness returning sdo.
  modport master (
    output start, wdata, sdo,
    input  busy, done, rdata, sdi, stb
  );

  // Sequencer side.
  modport slave (
    input  start, wdata, sdo,
    output busy, done, rdata, sdi, stb
  );
endinterface

// File: rtl/roi_harness_seq.sv
// Sequencer: load a word twice into the harness chain, strobe after each load,
// then shift the captured ROI response back into a parallel word.
module roi_harness_seq
  import roi_harness_pkg::*;
#(
  parameter int DIN_N  = 256,
  parameter int DOUT_N = 256
) (
  input  logic            clk,
  input  logic            rst,
  roi_harness_seq_if.slave bus
);

  localparam int CW = cnt_w(DIN_N, DOUT_N);
  localparam logic [CW-1:0] DIN_LAST  = CW'(DIN_N - 1);
  localparam logic [CW-1:0] DOUT_LAST = CW'(DOUT_N - 1);

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [DIN_N-1:0]  wq_reg;
  logic [DOUT_N-1:0] rdata_reg;
  logic              sdi_reg, sdi_next;
  logic              stb_reg, stb_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic [DIN_N-1:0]  shift_src;
  logic [DIN_N-1:0]  shift_view;

  // State and position counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and counter logic; the counter wraps to 0 whenever a shift/read phase ends.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_SHIFT1;
          cnt_next   = '0;
        end
      end
      ST_SHIFT1: begin
        if (cnt_reg == DIN_LAST) begin
          state_next = ST_STB1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_STB1: state_next = ST_SHIFT2;
      ST_SHIFT2: begin
        if (cnt_reg == DIN_LAST) begin
          state_next = ST_STB2;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_STB2: state_next = ST_READ;
      ST_READ: begin
        if (cnt_reg == DOUT_LAST) begin
          state_next = ST_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so the pins are registered yet aligned
  // with the state they belong to. On the accept edge wq is not loaded yet, so
  // the first bit comes straight from wdata.
  always_comb begin
    shift_src  = (state_reg == ST_IDLE) ? bus.wdata : wq_reg;
    shift_view = shift_src << cnt_next;
    sdi_next   = 1'b0;
    if (state_next == ST_SHIFT1 || state_next == ST_SHIFT2) begin
      sdi_next = shift_view[DIN_N-1];
    end
    stb_next  = (state_next == ST_STB1) || (state_next == ST_STB2);
    busy_next = (state_next != ST_IDLE);
    done_next = (state_next == ST_DONE);
  end

  // Registered harness pins and host status.
  always_ff @(posedge clk) begin
    if (rst) begin
      sdi_reg  <= 1'b0;
      stb_reg  <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      sdi_reg  <= sdi_next;
      stb_reg  <= stb_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
    end
  end

  // Word latch on accept and MSB-first readback shift during READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      wq_reg    <= '0;
      rdata_reg <= '0;
    end else if (state_reg == ST_IDLE && bus.start) begin
      wq_reg    <= bus.wdata;
      rdata_reg <= '0;
    end else if (state_reg == ST_READ) begin
      rdata_reg <= {rdata_reg[DOUT_N-2:0], bus.sdo};
    end
  end

  assign bus.sdi   = sdi_reg;
  assign bus.stb   = stb_reg;
  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
  assign bus.rdata = rdata_reg;

endmodule

// File: doc/roi_harness_seq.md
# roi_harness_seq

Sequencer for the serial ROI test harness. It takes one parallel input word and shifts it MSB-first into the harness `din` shift chain, then pulses the harness strobe. It repeats the shift and strobe a second time so the harness captures the ROI's response to the first load. It then shifts that response back out of the harness `do` line into a parallel readback word. It sits between a host/test driver and the harness's `di`/`stb`/`do` pins, and replaces hand-toggled strobe and shift sequences in fuzzer minitests.

## Interface

Parameters:
- `DIN_N`, 256, width of harness input chain and `wdata`; ≥2
- `DOUT_N`, 256, width of harness output chain and `rdata`; ≥2

Ports:
- `clk`  in  1  single clock; every register in the block is on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  request a transaction; accepted only when `busy`=0
- `wdata`  in  DIN_N  word to load; sampled on the accept edge only
- `busy`  out  1  high from the cycle after accept through the DONE cycle
- `done`  out  1  single-cycle pulse; `rdata` is valid from this cycle on
- `rdata`  out  DOUT_N  captured ROI output; held until the next accept or reset
- `sdi`  out  1  drives harness `di`; registered
- `stb`  out  1  drives harness `stb`; registered
- `sdo`  in  1  from harness `do`

## Operation

- States: IDLE → SHIFT1 → STB1 → SHIFT2 → STB2 → READ → DONE → IDLE.
- Accept: the edge where `start`=1 in IDLE. That edge latches `wdata` into `wq`, clears `rdata` and the counter, and enters SHIFT1. `start` in any other state is ignored and is not queued.
- SHIFT1/SHIFT2:
  - DIN_N cycles each.
  - In cycle k (k = 0..DIN_N-1), `sdi` = `wq[DIN_N-1-k]`.
  - Counter k wraps to 0 on leaving the state.
- STB1/STB2:
  - One cycle each, `stb`=1, `sdi`=0.
  - STB1 loads the harness `din`.
  - STB2 captures the ROI output into the harness `dout_shr` and reloads the identical word.
- READ:
  - DOUT_N cycles.
  - Each cycle: `rdata <= {rdata[DOUT_N-2:0], sdo}`.
  - `sdi`=0 and `stb`=0.
- DONE: one cycle, `done`=1, `busy`=1, then IDLE.
- Counter width: `$clog2(max(DIN_N,DOUT_N))`. Compare against N-1 so no overflow is possible.

## Timing

- Reset values: `busy`=0, `done`=0, `stb`=0, `sdi`=0, `rdata`=0, state IDLE, `wq`=0, counter 0.
- Reset mid-operation:
  - Next cycle is IDLE with every output at its reset value.
  - No `done` pulse.
  - Harness contents are undefined afterwards.
- `rst` and `start` high in the same cycle: reset wins and nothing is accepted.
- Accept at edge 0. Cycle-level schedule after accept:
  - SHIFT1: cycles 1..DIN_N
  - STB1: cycle DIN_N+1
  - SHIFT2: cycles DIN_N+2..2·DIN_N+1
  - STB2: cycle 2·DIN_N+2
  - READ: next DOUT_N cycles
  - DONE: cycle 2·DIN_N+DOUT_N+3
- Transaction length: 2·DIN_N+DOUT_N+3 cycles from accept to `done`.
- Earliest next accept: the IDLE cycle after DONE, so back-to-back spacing is +1 cycle.
- `stb` is never high in two consecutive cycles. `stb` and `done` are never high together.
- `rdata` is stable from DONE until the next accept edge.

## Structure

- Shared package `roi_harness_pkg`:
  - state enum
  - `cnt_w(DIN_N,DOUT_N)` width function
  - localparam for the transaction length, reused by harness testbenches
- Single module. No sub-module is natural, because the shift and capture logic is a few lines each.

## Test plan

All scenarios use DIN_N=DOUT_N=8, a behavioural harness model, and an identity ROI.

- Load `wdata`=8'hA5 → `stb` high exactly at cycles 9 and 18; `done` at cycle 27; `rdata`=8'hA5.
- `wdata`=8'h80, then 8'h01 back-to-back (second `start` held high through DONE) → first `rdata`=8'h80; second accept at cycle 28; second `rdata`=8'h01 with `done` at cycle 55.
- `start` pulsed during SHIFT2 and during DONE → ignored; exactly one `done`; `busy` low at cycle 28.
- `rst` asserted at cycle 12 (in SHIFT2) → cycle 13 IDLE with `busy`/`stb`/`sdi`/`done`/`rdata`=0; no `done` pulse ever follows.
- ROI model inverting (`dout`=~`din`), `wdata`=8'h3C → `rdata`=8'hC3. This checks that STB2 captures the first load, not the stale value.
- Same scenario at DIN_N=4, DOUT_N=12, ROI zero-extends, `wdata`=4'h9 → `rdata`=12'h009; `done` at cycle 23.
